// File: rtl/multicycle_datapath_if.sv
// Unified instruction/data memory port of the multicycle datapath.
// The datapath is the master: it drives the address and the store data and receives the read data.
interface multicycle_datapath_if;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output adr, output writedata, input readdata);
    modport slave  (input adr, input writedata, output readdata);
endinterface

// File: rtl/multicycle_datapath.sv
// RISC-V multicycle datapath: holds PC/OldPC/IR/Data/A/WriteData/ALUOut and the register file.
// It executes the control words of an external controller and has no sequencing of its own.
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  immsrc,
    input  logic [1:0]                  alusrca,
    input  logic [1:0]                  alusrcb,
    input  logic [1:0]                  resultsrc,
    input  logic                        adrsrc,
    input  logic [2:0]                  alucontrol,
    input  logic                        irwrite,
    input  logic                        pcwrite,
    input  logic                        regwrite,
    output logic [6:0]                  op,
    output logic [2:0]                  funct3,
    output logic                        funct7b5,
    output logic                        zero,
    multicycle_datapath_if.master       mem
);

    logic [31:0] pc_q, old_pc_q, ir_q, data_q, a_q, write_data_q, alu_out_q;
    logic [31:0] pc_d, old_pc_d, ir_d;
    logic [31:0] rf_q [32];

    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2;
    logic [31:0] imm_ext;
    logic [31:0] src_a, src_b;
    logic [31:0] alu_result;
    logic [31:0] result;

    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign rd  = ir_q[11:7];

    assign op       = ir_q[6:0];
    assign funct3   = ir_q[14:12];
    assign funct7b5 = ir_q[30];

    // x0 is hard-wired to zero on both read ports.
    assign rd1 = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rd2 = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    always_comb begin
        imm_ext = 32'd0;
        case (immsrc)
            2'b00:   imm_ext = {{20{ir_q[31]}}, ir_q[31:20]};
            2'b01:   imm_ext = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            2'b10:   imm_ext = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            default: imm_ext = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
        endcase
    end

    always_comb begin
        src_a = 32'd0;
        case (alusrca)
            2'b00:   src_a = pc_q;
            2'b01:   src_a = old_pc_q;
            2'b10:   src_a = a_q;
            default: src_a = 32'd0;
        endcase
    end

    always_comb begin
        src_b = 32'd0;
        case (alusrcb)
            2'b00:   src_b = write_data_q;
            2'b01:   src_b = imm_ext;
            2'b10:   src_b = 32'd4;
            default: src_b = 32'd0;
        endcase
    end

    always_comb begin
        alu_result = 32'd0;
        case (alucontrol)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
    end

    assign zero = (alu_result == 32'd0);

    always_comb begin
        result = 32'd0;
        case (resultsrc)
            2'b00:   result = alu_out_q;
            2'b01:   result = data_q;
            2'b10:   result = alu_result;
            default: result = 32'd0;
        endcase
    end

    assign mem.adr       = adrsrc ? result : pc_q;
    assign mem.writedata = write_data_q;

    // OldPC takes the pre-update PC so fetch can bump PC on the same edge.
    always_comb begin
        pc_d     = pcwrite ? result : pc_q;
        ir_d     = irwrite ? mem.readdata : ir_q;
        old_pc_d = irwrite ? pc_q : old_pc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            old_pc_q     <= 32'd0;
            ir_q         <= 32'd0;
            data_q       <= 32'd0;
            a_q          <= 32'd0;
            write_data_q <= 32'd0;
            alu_out_q    <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            old_pc_q     <= old_pc_d;
            ir_q         <= ir_d;
            data_q       <= mem.readdata;
            a_q          <= rd1;
            write_data_q <= rd2;
            alu_out_q    <= alu_result;
        end
    end

    // Register file contents survive reset; only the write on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset && regwrite && (rd != 5'd0)) begin
            rf_q[rd] <= result;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench: plays the controller for lw/sw/R/I/beq/jal and compares against an ISA-level model.
module tb_multicycle_datapath;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  immsrc, alusrca, alusrcb, resultsrc;
    logic        adrsrc;
    logic [2:0]  alucontrol;
    logic        irwrite, pcwrite, regwrite;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;

    multicycle_datapath_if mem_if ();

    always #5 clk = ~clk;

    multicycle_datapath #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .immsrc     (immsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .adrsrc     (adrsrc),
        .alucontrol (alucontrol),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regwrite   (regwrite),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem        (mem_if)
    );

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    // Architectural reference state
    logic [31:0] m_rf [32];
    bit          m_valid [32];
    logic [31:0] m_pc;
    logic [31:0] m_mem [logic [31:0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        if (m_mem.exists(addr)) return m_mem[addr];
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // ISA semantics for the supported ALU operations.
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit is_sub,
                                            input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return is_sub ? a - b : a + b;
            3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] ctl_code(input logic [2:0] f3, input bit is_sub);
        case (f3)
            3'b000:  return is_sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input bit sub, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {1'b0, sub, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic set_ctl(input logic [1:0] is, input logic [1:0] sa, input logic [1:0] sb,
                           input logic [1:0] rs, input logic ads, input logic [2:0] ac,
                           input logic irw, input logic pcw, input logic rgw);
        immsrc = is; alusrca = sa; alusrcb = sb; resultsrc = rs; adrsrc = ads;
        alucontrol = ac; irwrite = irw; pcwrite = pcw; regwrite = rgw;
    endtask

    task automatic cycle_end();
        @(posedge clk);
        #1;
    endtask

    // Last cycle of a writing instruction; an abort asserts reset on the write edge.
    task automatic wb_edge(input logic [4:0] rd, input logic [31:0] val, input bit abort);
        if (abort) begin
            reset = 1'b1;
            cycle_end();
            reset = 1'b0;
            m_pc = RST_PC;
        end else begin
            cycle_end();
            if (rd != 5'd0) begin
                m_rf[rd] = val;
                m_valid[rd] = 1'b1;
            end
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input bit abort);
        logic [6:0]  opc;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] a, b, imm_i, imm_s, imm_b, imm_j, old_pc, eff, val, res, tgt;
        logic [1:0]  dec_imm;
        bit          taken, is_sub;

        opc = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        a = m_rf[rs1];
        b = m_rf[rs2];
        old_pc = m_pc;
        $display("txn %0d pc=%h instr=%h", txn, m_pc, ins);
        txn++;

        // Fetch
        set_ctl(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
        mem_if.readdata = ins;
        @(negedge clk);
        check_eq("fetch_adr", mem_if.adr, m_pc);
        cycle_end();
        m_pc = old_pc + 32'd4;

        // Decode
        dec_imm = (opc == 7'b1100011) ? 2'b10 : (opc == 7'b1101111) ? 2'b11 : 2'b00;
        set_ctl(dec_imm, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        mem_if.readdata = $urandom;
        @(negedge clk);
        check_eq("op", {25'd0, op}, {25'd0, opc});
        check_eq("funct3", {29'd0, funct3}, {29'd0, f3});
        check_eq("funct7b5", {31'd0, funct7b5}, {31'd0, ins[30]});
        check_eq("pc_plus4", mem_if.adr, m_pc);
        cycle_end();

        if (m_valid[rs2]) check_eq("rs2_read", mem_if.writedata, b);

        case (opc)
            7'b0000011, 7'b0100011: begin
                eff = a + ((opc == 7'b0000011) ? imm_i : imm_s);
                set_ctl((opc == 7'b0000011) ? 2'b00 : 2'b01, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
                cycle_end();
                if (opc == 7'b0000011) begin
                    val = mem_rd(eff);
                    set_ctl(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
                    mem_if.readdata = val;
                    @(negedge clk);
                    check_eq("lw_adr", mem_if.adr, eff);
                    cycle_end();
                    set_ctl(2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
                    mem_if.readdata = $urandom;
                    @(negedge clk);
                    check_eq("lw_data", mem_if.adr, val);
                    wb_edge(rd, val, abort);
                end else begin
                    set_ctl(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
                    @(negedge clk);
                    check_eq("sw_adr", mem_if.adr, eff);
                    check_eq("sw_data", mem_if.writedata, b);
                    cycle_end();
                    m_mem[eff] = b;
                end
            end
            7'b0110011, 7'b0010011: begin
                is_sub = (opc == 7'b0110011) && ins[30];
                res = ref_alu(f3, is_sub, a, (opc == 7'b0110011) ? b : imm_i);
                set_ctl(2'b00, 2'b10, (opc == 7'b0110011) ? 2'b00 : 2'b01, 2'b00, 1'b0,
                        ctl_code(f3, is_sub), 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                check_eq("exec_zero", {31'd0, zero}, {31'd0, (res == 32'd0)});
                cycle_end();
                set_ctl(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
                @(negedge clk);
                check_eq("alu_result", mem_if.adr, res);
                wb_edge(rd, res, abort);
            end
            7'b1100011: begin
                taken = (a == b);
                tgt = old_pc + imm_b;
                set_ctl(2'b10, 2'b10, 2'b00, 2'b00, 1'b1, 3'b001, 1'b0, taken, 1'b0);
                @(negedge clk);
                check_eq("beq_zero", {31'd0, zero}, {31'd0, taken});
                check_eq("beq_target", mem_if.adr, tgt);
                cycle_end();
                if (taken) m_pc = tgt;
            end
            default: begin
                tgt = old_pc + imm_j;
                set_ctl(2'b11, 2'b01, 2'b10, 2'b00, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
                @(negedge clk);
                check_eq("jal_target", mem_if.adr, tgt);
                cycle_end();
                m_pc = tgt;
                set_ctl(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
                @(negedge clk);
                check_eq("jal_link", mem_if.adr, old_pc + 32'd4);
                wb_edge(rd, old_pc + 32'd4, abort);
            end
        endcase
    endtask

    // Reset with every enable high; architectural registers except the RF return to reset values.
    task automatic reset_all_enables();
        set_ctl(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1);
        mem_if.readdata = $urandom;
        reset = 1'b1;
        cycle_end();
        reset = 1'b0;
        set_ctl(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        m_pc = RST_PC;
        @(negedge clk);
        check_eq("rst_adr", mem_if.adr, RST_PC);
        check_eq("rst_op", {25'd0, op}, 32'd0);
        check_eq("rst_funct3", {29'd0, funct3}, 32'd0);
        check_eq("rst_funct7b5", {31'd0, funct7b5}, 32'd0);
        check_eq("rst_writedata", mem_if.writedata, 32'd0);
        cycle_end();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm12;
        logic [12:0] immb;
        logic [20:0] immj;
        logic [2:0]  f3;
        int          k;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        imm12 = 12'($urandom);
        k = $urandom_range(0, 9);
        case (k)
            0: return enc_r(1'($urandom), rs2, rs1, 3'b000, rd);
            1: begin
                case ($urandom_range(0, 2))
                    0: f3 = 3'b111;
                    1: f3 = 3'b110;
                    default: f3 = 3'b010;
                endcase
                return enc_r(1'b0, rs2, rs1, f3, rd);
            end
            2, 3: begin
                case ($urandom_range(0, 3))
                    0: f3 = 3'b000;
                    1: f3 = 3'b010;
                    2: f3 = 3'b110;
                    default: f3 = 3'b111;
                endcase
                return enc_i(imm12, rs1, f3, rd, 7'b0010011);
            end
            4: return enc_i(imm12, rs1, 3'b010, rd, 7'b0000011);
            5: return enc_s(imm12, rs2, rs1);
            6, 7: begin
                immb = {13'($urandom) & 13'h1FFE};
                return enc_b(immb, ($urandom_range(0, 1) == 0) ? rs1 : rs2, rs1);
            end
            8: begin
                immj = 21'($urandom) & 21'h1FFFFE;
                return enc_j(immj, rd);
            end
            default: return enc_r(1'b1, rs1, rs1, 3'b000, rd);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = 32'd0;
            m_valid[i] = (i == 0);
        end
        m_pc = RST_PC;
        reset = 1'b1;
        set_ctl(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        mem_if.readdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // addi x5,x0,7 then reset with all enables high; x5 must survive
        run_instr(32'h0070_0293, 1'b0);
        reset_all_enables();
        run_instr(enc_r(1'b0, 5'd5, 5'd0, 3'b000, 5'd0), 1'b0);

        // initialise the remaining registers
        for (int r = 1; r < 32; r++) begin
            if (r != 5) run_instr(enc_i(12'($urandom), 5'd0, 3'b000, 5'(r), 7'b0010011), 1'b0);
        end

        // overflow add, sub to zero, signed slt both ways
        m_mem[32'h10] = 32'h7FFF_FFFF;
        run_instr(enc_i(12'h010, 5'd0, 3'b010, 5'd1, 7'b0000011), 1'b0);
        run_instr(enc_i(12'h001, 5'd0, 3'b000, 5'd2, 7'b0010011), 1'b0);
        run_instr(enc_r(1'b0, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0);
        run_instr(enc_r(1'b1, 5'd1, 5'd1, 3'b000, 5'd4), 1'b0);
        run_instr(enc_i(12'hFFF, 5'd0, 3'b000, 5'd3, 7'b0010011), 1'b0);
        run_instr(enc_r(1'b0, 5'd2, 5'd3, 3'b010, 5'd4), 1'b0);
        run_instr(enc_r(1'b0, 5'd3, 5'd2, 3'b010, 5'd4), 1'b0);

        // sw x5,8(x0); lw x6,8(x0)
        run_instr(enc_s(12'd8, 5'd5, 5'd0), 1'b0);
        run_instr(enc_i(12'd8, 5'd0, 3'b010, 5'd6, 7'b0000011), 1'b0);

        // beq x0,x0,-8 and jal x1,+16
        run_instr(enc_b(13'h1FF8, 5'd0, 5'd0), 1'b0);
        run_instr(enc_j(21'd16, 5'd1), 1'b0);

        // writes to x0 are discarded
        run_instr(enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011), 1'b0);
        run_instr(enc_r(1'b0, 5'd0, 5'd5, 3'b000, 5'd8), 1'b0);

        // reset on the writeback edge: no PC advance, x7 unchanged
        run_instr(enc_i(12'd99, 5'd0, 3'b000, 5'd7, 7'b0010011), 1'b1);
        run_instr(enc_r(1'b0, 5'd7, 5'd0, 3'b000, 5'd9), 1'b0);

        for (int n = 0; n < 300; n++) begin
            run_instr(rand_instr(), ($urandom_range(0, 29) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
